// File: rtl/sec_countdown_pkg.sv
// Shared definitions for the seconds countdown timer: FSM state encoding and
// default prescaler divisors for 50 MHz hardware and for fast simulation.
package sec_countdown_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned DIV_HW  = 50_000_000;
  localparam int unsigned DIV_SIM = 4;

endpackage

// File: rtl/sec_countdown_tick_prescaler.sv
// Tick prescaler: counts enabled clocks 0..DIV-1 and emits a one-cycle tick
// on wrap. `wrap` is the same-cycle strobe so the owner can act on that edge.
module tick_prescaler
  import sec_countdown_pkg::*;
#(
  parameter int unsigned DIV       = DIV_HW,
  parameter int unsigned DIV_WIDTH = 26
) (
  input  logic clk_50MHz,
  input  logic res,
  input  logic clr,
  input  logic en,
  output logic wrap,
  output logic tick
);

  localparam logic [DIV_WIDTH-1:0] PCNT_MAX = DIV_WIDTH'(DIV - 1);
  localparam logic [DIV_WIDTH-1:0] PCNT_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                 tick_q, tick_d;

  always_comb begin
    wrap   = en && !clr && (pcnt_q == PCNT_MAX);
    pcnt_d = pcnt_q;
    tick_d = 1'b0;
    if (clr) begin
      pcnt_d = '0;
    end else if (wrap) begin
      pcnt_d = '0;
      tick_d = 1'b1;
    end else if (en) begin
      pcnt_d = pcnt_q + PCNT_ONE;
    end
  end

  always_ff @(posedge clk_50MHz or posedge res) begin
    if (res) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sec_countdown.sv
// Loadable seconds countdown with one-shot/auto-reload and pause.
// Optional blink square wave on clk_sq when SEC_COUNTDOWN_SQWAVE_EN is defined.
module sec_countdown
  import sec_countdown_pkg::*;
#(
  parameter int unsigned DIV       = DIV_HW,
  parameter int unsigned DIV_WIDTH = 26,
  parameter int unsigned CNT_WIDTH = 6
) (
  input  logic                 clk_50MHz,
  input  logic                 res,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] duration,
  input  logic                 auto_reload,
  input  logic                 pause,
  output logic                 tick,
  output logic [CNT_WIDTH-1:0] remaining,
  output logic                 busy,
  output logic                 done,
  output logic                 clk_sq
);

  localparam logic [CNT_WIDTH-1:0] REM_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 wrap;
  logic                 pre_en;

  // Prescaler only advances while running unpaused; start always realigns it.
  assign pre_en = (state_q == ST_RUN) && !pause;

  tick_prescaler #(
    .DIV       (DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk_50MHz (clk_50MHz),
    .res       (res),
    .clr       (start),
    .en        (pre_en),
    .wrap      (wrap),
    .tick      (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (start) begin
      if (duration == '0) begin
        state_d = ST_IDLE;
        rem_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        rem_d   = duration;
      end
    end else if ((state_q == ST_RUN) && wrap) begin
      if (rem_q == REM_ONE) begin
        done_d = 1'b1;
        if (auto_reload && (duration != '0)) begin
          rem_d = duration;
        end else begin
          rem_d   = '0;
          state_d = ST_IDLE;
        end
      end else if (rem_q != '0) begin
        rem_d = rem_q - REM_ONE;
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_50MHz or posedge res) begin
    if (res) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign remaining = rem_q;
  assign done      = done_q;
  assign busy      = busy_q;

`ifdef SEC_COUNTDOWN_SQWAVE_EN
  // Free-running half-period divider, independent of the countdown FSM.
  localparam logic [DIV_WIDTH-1:0] HALF_MAX = DIV_WIDTH'(DIV / 2 - 1);
  localparam logic [DIV_WIDTH-1:0] SQ_ONE   = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] sq_cnt_q, sq_cnt_d;
  logic                 sq_q, sq_d;

  always_comb begin
    sq_cnt_d = sq_cnt_q + SQ_ONE;
    sq_d     = sq_q;
    if (sq_cnt_q == HALF_MAX) begin
      sq_cnt_d = '0;
      sq_d     = ~sq_q;
    end
  end

  always_ff @(posedge clk_50MHz or posedge res) begin
    if (res) begin
      sq_cnt_q <= '0;
      sq_q     <= 1'b0;
    end else begin
      sq_cnt_q <= sq_cnt_d;
      sq_q     <= sq_d;
    end
  end

  assign clk_sq = sq_q;
`else
  assign clk_sq = 1'b0;
`endif

endmodule

// File: tb/tb_sec_countdown.sv
// Directed self-checking bench for sec_countdown with DIV=4, CNT_WIDTH=4.
module tb_sec_countdown;

  localparam int DIV       = 4;
  localparam int DIV_WIDTH = 3;
  localparam int CNT_WIDTH = 4;

  logic                 clk_50MHz = 1'b0;
  logic                 res = 1'b1;
  logic                 start = 1'b0;
  logic [CNT_WIDTH-1:0] duration = '0;
  logic                 auto_reload = 1'b0;
  logic                 pause = 1'b0;
  logic                 tick;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 busy;
  logic                 done;
  logic                 clk_sq;

  int checks = 0;
  int failures = 0;

  sec_countdown #(
    .DIV       (DIV),
    .DIV_WIDTH (DIV_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .res         (res),
    .start       (start),
    .duration    (duration),
    .auto_reload (auto_reload),
    .pause       (pause),
    .tick        (tick),
    .remaining   (remaining),
    .busy        (busy),
    .done        (done),
    .clk_sq      (clk_sq)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  task automatic cyc();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic do_start(input logic [CNT_WIDTH-1:0] dur, input logic ar);
    duration    = dur;
    auto_reload = ar;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    $display("txn start dur=%0d auto_reload=%b -> busy=%b rem=%0d done=%b", dur, ar, busy, remaining, done);
  endtask

  task automatic test_reset();
    res = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({tick, busy, done, clk_sq} !== 4'b0000 || remaining !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got tick=%b busy=%b done=%b sq=%b rem=%0d exp all 0", tick, busy, done, clk_sq, remaining);
    end
    res = 1'b0;
    cyc();
    do_start(4'd5, 1'b0);
    cyc();
    cyc();
    checks++;
    if (remaining !== 4'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_prerun got rem=%0d busy=%b exp rem=5 busy=1", remaining, busy);
    end
    #2 res = 1'b1;
    #1;
    checks++;
    if ({tick, busy, done, clk_sq} !== 4'b0000 || remaining !== 4'd0) begin
      failures++;
      $display("FAIL reset_async got tick=%b busy=%b done=%b sq=%b rem=%0d exp all 0", tick, busy, done, clk_sq, remaining);
    end
    cyc();
    res = 1'b0;
    for (int n = 0; n < 30; n++) begin
      cyc();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || remaining !== 4'd0) begin
        failures++;
        $display("FAIL reset_after n=%0d got done=%b busy=%b rem=%0d exp 0 0 0", n, done, busy, remaining);
      end
    end
    $display("txn reset mid-run complete");
  endtask

  task automatic test_oneshot();
    logic et, ed, eb;
    logic [CNT_WIDTH-1:0] er;
    do_start(4'd3, 1'b0);
    checks++;
    if ({tick, done, busy} !== 3'b001 || remaining !== 4'd3) begin
      failures++;
      $display("FAIL oneshot_load got tick=%b done=%b busy=%b rem=%0d exp 0 0 1 rem=3", tick, done, busy, remaining);
    end
    for (int n = 1; n <= 14; n++) begin
      cyc();
      et = (n % 4 == 0) && (n <= 12);
      ed = (n == 12);
      eb = (n < 12);
      er = (n >= 12) ? 4'd0 : CNT_WIDTH'(3 - n / 4);
      checks++;
      if ({tick, done, busy} !== {et, ed, eb} || remaining !== er) begin
        failures++;
        $display("FAIL oneshot n=%0d got tick=%b done=%b busy=%b rem=%0d exp %b %b %b rem=%0d", n, tick, done, busy, remaining, et, ed, eb, er);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic et, ed;
    logic [CNT_WIDTH-1:0] er;
    do_start(4'd2, 1'b1);
    duration = 4'd1;
    checks++;
    if (busy !== 1'b1 || remaining !== 4'd2) begin
      failures++;
      $display("FAIL reload_load got busy=%b rem=%0d exp busy=1 rem=2", busy, remaining);
    end
    for (int n = 1; n <= 14; n++) begin
      cyc();
      et = (n % 4 == 0);
      ed = (n == 8) || (n == 12);
      er = (n < 4) ? 4'd2 : 4'd1;
      checks++;
      if ({tick, done, busy} !== {et, ed, 1'b1} || remaining !== er) begin
        failures++;
        $display("FAIL reload n=%0d got tick=%b done=%b busy=%b rem=%0d exp %b %b 1 rem=%0d", n, tick, done, busy, remaining, et, ed, er);
      end
    end
    do_start(4'd0, 1'b0);
    checks++;
    if ({tick, done, busy} !== 3'b010 || remaining !== 4'd0) begin
      failures++;
      $display("FAIL reload_stop0 got tick=%b done=%b busy=%b rem=%0d exp 0 1 0 rem=0", tick, done, busy, remaining);
    end
    cyc();
  endtask

  task automatic test_pause();
    logic et, ed, eb;
    logic [CNT_WIDTH-1:0] er;
    do_start(4'd2, 1'b0);
    for (int n = 1; n <= 13; n++) begin
      cyc();
      et = (n == 4) || (n == 11);
      ed = (n == 11);
      eb = (n < 11);
      er = (n < 4) ? 4'd2 : ((n < 11) ? 4'd1 : 4'd0);
      checks++;
      if ({tick, done, busy} !== {et, ed, eb} || remaining !== er) begin
        failures++;
        $display("FAIL pause n=%0d got tick=%b done=%b busy=%b rem=%0d exp %b %b %b rem=%0d", n, tick, done, busy, remaining, et, ed, eb, er);
      end
      if (n == 5) pause = 1'b1;
      if (n == 8) pause = 1'b0;
    end
  endtask

  task automatic test_restart();
    logic et, ed, eb;
    logic [CNT_WIDTH-1:0] er;
    int m;
    do_start(4'd3, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (n < 6) begin
        et = (n == 4);
        ed = 1'b0;
        eb = 1'b1;
        er = (n < 4) ? 4'd3 : 4'd2;
      end else begin
        m  = n - 6;
        et = (m > 0) && (m % 4 == 0) && (m <= 12);
        ed = (m == 12);
        eb = (m < 12);
        er = (m >= 12) ? 4'd0 : CNT_WIDTH'(3 - m / 4);
      end
      checks++;
      if ({tick, done, busy} !== {et, ed, eb} || remaining !== er) begin
        failures++;
        $display("FAIL restart n=%0d got tick=%b done=%b busy=%b rem=%0d exp %b %b %b rem=%0d", n, tick, done, busy, remaining, et, ed, eb, er);
      end
      if (n == 5) begin
        duration = 4'd3;
        start    = 1'b1;
      end
      if (n == 6) start = 1'b0;
    end
  endtask

  task automatic test_zero_start();
    do_start(4'd0, 1'b0);
    checks++;
    if ({tick, done, busy} !== 3'b010 || remaining !== 4'd0) begin
      failures++;
      $display("FAIL zero_start got tick=%b done=%b busy=%b rem=%0d exp 0 1 0 rem=0", tick, done, busy, remaining);
    end
    for (int n = 1; n <= 4; n++) begin
      cyc();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL zero_after n=%0d got done=%b busy=%b exp 0 0", n, done, busy);
      end
    end
  endtask

  task automatic test_clk_sq();
    logic x [0:9];
    for (int i = 0; i < 10; i++) begin
      cyc();
      x[i] = clk_sq;
    end
`ifdef SEC_COUNTDOWN_SQWAVE_EN
    for (int n = 2; n < 10; n++) begin
      checks++;
      if (x[n] !== ~x[n-2]) begin
        failures++;
        $display("FAIL clk_sq_period n=%0d got %b exp %b", n, x[n], ~x[n-2]);
      end
    end
`else
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (x[n] !== 1'b0) begin
        failures++;
        $display("FAIL clk_sq_tied n=%0d got %b exp 0", n, x[n]);
      end
    end
`endif
    $display("txn clk_sq observed over 10 cycles");
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_pause();
    test_restart();
    test_zero_start();
    test_clk_sq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sec_countdown.md
# sec_countdown

Parametrised seconds countdown timer for the traffic-light FSMs. An internal prescaler divides `clk_50MHz` down to a one-cycle `tick` every `DIV` clocks. A loadable down-counter counts those ticks from `duration` to zero and then pulses `done`, in one-shot or auto-reload mode, with pause support. It replaces free-running divide-by-N timers: the FSM loads a phase length and waits for `done` instead of counting seconds itself.

## Interface
Parameters:
- `DIV`, 50_000_000 — clocks per tick; legal range ≥ 2 (simulation benches override to small values).
- `DIV_WIDTH`, 26 — prescaler counter width; must satisfy 2^DIV_WIDTH ≥ DIV.
- `CNT_WIDTH`, 6 — width of `duration` and `remaining`; maximum 63 ticks.

Ports:
- `clk_50MHz`  in  1  system clock.
- `res`  in  1  asynchronous, active-high reset.
- `start`  in  1  load `duration` and (re)start counting.
- `duration`  in  CNT_WIDTH  phase length in ticks; sampled on `start` and on auto-reload.
- `auto_reload`  in  1  sampled at expiry: 1 = reload and continue, 0 = stop.
- `pause`  in  1  freezes prescaler and counter while in RUN.
- `tick`  out  1  one-cycle pulse per elapsed tick period in RUN.
- `remaining`  out  CNT_WIDTH  ticks left.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at expiry.
- `clk_sq`  out  1  square wave of period `DIV` clocks (see Configuration).

## Operation
- States: IDLE and RUN.
- Reset values: state IDLE, `pcnt` 0, `remaining` 0, and `tick`, `done`, `busy`, `clk_sq` all 0.
- **IDLE, `start`=1, `duration`≠0:**
  - `remaining`←`duration`, `pcnt`←0, go to RUN.
- **IDLE, `start`=1, `duration`=0:**
  - `done`←1 for one cycle, stay in IDLE.
- **RUN, `start`=1:**
  - Restart: `remaining`←`duration` (or `done` pulse + IDLE if `duration`=0), `pcnt`←0.
  - `start` has priority over `pause` and over tick/expiry on the same edge.
- **RUN, `pause`=1:**
  - `pcnt` and `remaining` hold; no `tick`.
  - `busy` stays 1.
- **RUN, `pause`=0, `pcnt`<DIV-1:**
  - `pcnt`←`pcnt`+1.
- **RUN, `pause`=0, `pcnt`=DIV-1:**
  - `pcnt`←0, `tick`←1, `remaining`←`remaining`-1.
- **Expiry** (a tick with `remaining`=1):
  - `done`←1.
  - If `auto_reload`=1: `remaining`←`duration` (new value sampled), stay in RUN.
  - If `auto_reload`=0: `remaining`←0, go to IDLE.
- **Auto-reload with `duration`=0 at expiry:** go to IDLE with `remaining`=0.
- Counters never wrap: `remaining` never decrements below 0, and `pcnt` never exceeds DIV-1.
- `busy` = (state == RUN), registered.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `start` sampled at edge k: from edge k, `busy`=1 and `remaining`=`duration`.
- With no pause, the first `tick` and the first decrement occur at edge k+DIV.
- Expiry occurs at edge k+`duration`·DIV. At that same edge `done`=1 and, in one-shot mode, `busy`=0.
- Each paused cycle delays all later events by exactly one clock.
- `tick` and `done` are high for exactly one cycle each.
- Auto-reload keeps the period seamless: the next tick follows DIV clocks after the expiry edge.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronously); no `done` pulse is produced.

## Configuration
- Macro: `SEC_COUNTDOWN_SQWAVE_EN`.
- **Defined:**
  - A free-running divider toggles `clk_sq` every DIV/2 clocks (DIV must be even), regardless of state, `pause` or `start`.
  - Used for blinking lamps.
- **Undefined:**
  - The divider is not built.
  - `clk_sq` is tied to 0 so the port list stays stable.

## Structure
- Shared package `sec_countdown_pkg`:
  - State encoding (IDLE=0, RUN=1).
  - Default `DIV` constants for 50 MHz hardware and for simulation.
- One sub-module: `tick_prescaler`.
  - Ports: `clk_50MHz`, `res`, `clr`, `en`.
  - Contains `pcnt` and generates the `tick` pulse.
  - The FSM and down-counter stay in `sec_countdown`.

## Test plan
All scenarios use DIV=4, CNT_WIDTH=4, macro defined unless stated.
- Reset during RUN with `remaining`=5 → all outputs read 0 immediately; no `done` after release.
- `start`, `duration`=3, `auto_reload`=0 → ticks at +4, +8 and +12 clocks; `remaining` 3→2→1→0; `done` and `busy`=0 at +12.
- `duration`=2, `auto_reload`=1, `duration` changed to 1 before the first expiry → `done` at +8, then again at +12; `busy` stays 1.
- Pause held for 3 cycles during the second tick period of a `duration`=2 run → `done` at +11 instead of +8.
- `start` re-asserted at +6 of a `duration`=3 run → `remaining`=3 again; `done` at +18.
- `start` with `duration`=0 → single `done` pulse, `busy` never rises. Separately, check `clk_sq` period is 4 clocks; with the macro undefined, `clk_sq` stays 0.
